// File: rtl/transformation_pkg.sv
// Shared types and elaboration-time helpers for the feature-transformation engine.
// Covers FSM state encoding, accumulator sizing, lane grouping and default address bases.
package transformation_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_W  = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam int WEIGHT_BASE_DEFAULT  = 32'sd0;
  localparam int FEATURE_BASE_DEFAULT = 32'sd512;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter widths never collapse to zero bits, even for single-entry ranges
  function automatic int clog2_min1(input int n);
    return (n > 32'sd1) ? $clog2(n) : 32'sd1;
  endfunction

  function automatic int acc_width(input int fw, input int ww, input int cols);
    return fw + ww + $clog2(cols);
  endfunction

  function automatic int group_count(input int cols, input int lanes);
    return (cols + lanes - 32'sd1) / lanes;
  endfunction

  // The last group may cover fewer columns than there are lanes
  function automatic int lanes_in_group(input int g, input int lanes, input int cols);
    int rem;
    rem = cols - g * lanes;
    return (rem < lanes) ? rem : lanes;
  endfunction

endpackage

// File: rtl/dot_product_lane.sv
// One compute lane: unsigned multiply-reduce of a feature row against a buffered
// weight column, clamped to the stored result width.
module dot_product_lane
  import transformation_pkg::*;
#(
  parameter int FEATURE_COLS   = 96,
  parameter int FEATURE_WIDTH  = 3,
  parameter int WEIGHT_WIDTH   = 5,
  parameter int DOT_PROD_WIDTH = 16
) (
  input  logic [FEATURE_COLS*FEATURE_WIDTH-1:0] features,
  input  logic [FEATURE_COLS*WEIGHT_WIDTH-1:0]  weights,
  output logic [DOT_PROD_WIDTH-1:0]             result,
  output logic                                  sat
);

  localparam int ACC_W = acc_width(FEATURE_WIDTH, WEIGHT_WIDTH, FEATURE_COLS);

  logic [ACC_W-1:0] acc_s;

  // Full-precision sum of products; operands widened first so no product bits are lost
  always_comb begin
    acc_s = '0;
    for (int i = 32'sd0; i < FEATURE_COLS; i++) begin
      acc_s = acc_s + ACC_W'(features[i*FEATURE_WIDTH +: FEATURE_WIDTH])
                    * ACC_W'(weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
    end
  end

  if (ACC_W > DOT_PROD_WIDTH) begin : g_clamp
    // Clamp to all-ones whenever any bit above the stored width is set
    always_comb begin
      if (|acc_s[ACC_W-1:DOT_PROD_WIDTH]) begin
        result = '1;
        sat    = 1'b1;
      end else begin
        result = acc_s[DOT_PROD_WIDTH-1:0];
        sat    = 1'b0;
      end
    end
  end else begin : g_pass
    assign result = DOT_PROD_WIDTH'(acc_s);
    assign sat    = 1'b0;
  end

endmodule

// File: rtl/transformation_engine.sv
// Computes the FEATURE_ROWS x WEIGHT_COLS product FM*WM from a shared read memory,
// LANES weight columns per pass, into a result matrix read row-wise downstream.
module transformation_engine
  import transformation_pkg::*;
#(
  parameter int FEATURE_ROWS   = 6,
  parameter int FEATURE_COLS   = 96,
  parameter int WEIGHT_COLS    = 3,
  parameter int LANES          = 2,
  parameter int FEATURE_WIDTH  = 3,
  parameter int WEIGHT_WIDTH   = 5,
  parameter int DOT_PROD_WIDTH = 16,
  parameter int ADDRESS_WIDTH  = 13,
  parameter int WEIGHT_BASE    = WEIGHT_BASE_DEFAULT,
  parameter int FEATURE_BASE   = FEATURE_BASE_DEFAULT
) (
  input  logic                                                          clk,
  input  logic                                                          reset,
  input  logic                                                          start,
  input  logic [FEATURE_COLS*max_int(FEATURE_WIDTH,WEIGHT_WIDTH)-1:0]   data_in,
  input  logic [clog2_min1(FEATURE_ROWS)-1:0]                           read_row,
  output logic                                                          enable_read,
  output logic [ADDRESS_WIDTH-1:0]                                      read_address,
  output logic                                                          busy,
  output logic                                                          done,
  output logic                                                          sat_flag,
  output logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0]                         fm_wm_row_out
);

  localparam int DW = max_int(FEATURE_WIDTH, WEIGHT_WIDTH);
  localparam int G  = group_count(WEIGHT_COLS, LANES);
  localparam int GW = clog2_min1(G);
  localparam int LW = clog2_min1(LANES);
  localparam int RW = clog2_min1(FEATURE_ROWS);

  state_t                      state_r, next_state_s;
  logic [GW-1:0]               group_r, group_s;
  logic [LW-1:0]               lane_r, lane_s;
  logic [RW-1:0]               row_r, row_s;
  logic                        cap_valid_r;
  logic [LW-1:0]               cap_lane_r;
  logic                        wr_valid_r;
  logic [RW-1:0]               wr_row_r;
  logic                        busy_r, done_r, enable_read_r, sat_flag_r;
  logic [ADDRESS_WIDTH-1:0]    read_address_r;
  logic                        busy_s, done_s, enable_read_s;
  logic [ADDRESS_WIDTH-1:0]    read_address_s;
  int                          active_lanes_s;
  logic                        any_sat_s;

  logic [WEIGHT_WIDTH-1:0]     scratch_r [LANES][FEATURE_COLS];
  logic [DOT_PROD_WIDTH-1:0]   result_r [FEATURE_ROWS][WEIGHT_COLS];

  logic [FEATURE_COLS*FEATURE_WIDTH-1:0] features_s;
  logic [FEATURE_COLS*WEIGHT_WIDTH-1:0]  lane_weights_s [LANES];
  logic [DOT_PROD_WIDTH-1:0]             lane_result_s [LANES];
  logic [LANES-1:0]                      lane_sat_s;

  // Number of lanes that own a real column in the current group
  always_comb begin
    active_lanes_s = lanes_in_group(int'(group_r), LANES, WEIGHT_COLS);
  end

  // State, counters, read-return tracking and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      group_r        <= '0;
      lane_r         <= '0;
      row_r          <= '0;
      cap_valid_r    <= 1'b0;
      cap_lane_r     <= '0;
      wr_valid_r     <= 1'b0;
      wr_row_r       <= '0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      enable_read_r  <= 1'b0;
      read_address_r <= '0;
    end else begin
      state_r        <= next_state_s;
      group_r        <= group_s;
      lane_r         <= lane_s;
      row_r          <= row_s;
      cap_valid_r    <= (state_r == ST_LOAD_W);
      cap_lane_r     <= lane_r;
      wr_valid_r     <= (state_r == ST_COMPUTE);
      wr_row_r       <= row_r;
      busy_r         <= busy_s;
      done_r         <= done_s;
      enable_read_r  <= enable_read_s;
      read_address_r <= read_address_s;
    end
  end

  // Next state and counter values
  always_comb begin
    next_state_s = state_r;
    group_s      = group_r;
    lane_s       = lane_r;
    row_s        = row_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          next_state_s = ST_LOAD_W;
          group_s      = '0;
          lane_s       = '0;
          row_s        = '0;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LOAD_W: begin
        if (int'(lane_r) == active_lanes_s - 32'sd1) begin
          next_state_s = ST_COMPUTE;
          lane_s       = '0;
          row_s        = '0;
        end else begin
          lane_s       = lane_r + 1'b1;
        end
      end
      ST_COMPUTE: begin
        if (int'(row_r) == FEATURE_ROWS - 32'sd1) begin
          next_state_s = ST_DRAIN;
          row_s        = '0;
        end else begin
          row_s        = row_r + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (int'(group_r) == G - 32'sd1) begin
          next_state_s = ST_DONE;
          group_s      = '0;
        end else begin
          next_state_s = ST_LOAD_W;
          group_s      = group_r + 1'b1;
          lane_s       = '0;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Output values for the upcoming cycle; the address holds whenever no read is issued
  always_comb begin
    busy_s         = (next_state_s != ST_IDLE);
    done_s         = (next_state_s == ST_DONE);
    enable_read_s  = 1'b0;
    read_address_s = read_address_r;
    case (next_state_s)
      ST_LOAD_W: begin
        enable_read_s  = 1'b1;
        read_address_s = ADDRESS_WIDTH'(WEIGHT_BASE + int'(group_s) * LANES + int'(lane_s));
      end
      ST_COMPUTE: begin
        enable_read_s  = 1'b1;
        read_address_s = ADDRESS_WIDTH'(FEATURE_BASE + int'(row_s));
      end
      default: begin
        enable_read_s  = 1'b0;
        read_address_s = read_address_r;
      end
    endcase
  end

  // Weight column returned from a LOAD_W read lands in its lane's scratch pad
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 32'sd0; k < LANES; k++) begin
        for (int i = 32'sd0; i < FEATURE_COLS; i++) begin
          scratch_r[k][i] <= '0;
        end
      end
    end else if (cap_valid_r) begin
      for (int k = 32'sd0; k < LANES; k++) begin
        if (int'(cap_lane_r) == k) begin
          for (int i = 32'sd0; i < FEATURE_COLS; i++) begin
            scratch_r[k][i] <= data_in[i*DW +: WEIGHT_WIDTH];
          end
        end
      end
    end
  end

  // Unpack the returned feature row and each lane's buffered weights
  always_comb begin
    features_s = '0;
    for (int k = 32'sd0; k < LANES; k++) begin
      lane_weights_s[k] = '0;
    end
    for (int i = 32'sd0; i < FEATURE_COLS; i++) begin
      features_s[i*FEATURE_WIDTH +: FEATURE_WIDTH] = data_in[i*DW +: FEATURE_WIDTH];
      for (int k = 32'sd0; k < LANES; k++) begin
        lane_weights_s[k][i*WEIGHT_WIDTH +: WEIGHT_WIDTH] = scratch_r[k][i];
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    dot_product_lane #(
      .FEATURE_COLS   (FEATURE_COLS),
      .FEATURE_WIDTH  (FEATURE_WIDTH),
      .WEIGHT_WIDTH   (WEIGHT_WIDTH),
      .DOT_PROD_WIDTH (DOT_PROD_WIDTH)
    ) u_lane (
      .features (features_s),
      .weights  (lane_weights_s[k]),
      .result   (lane_result_s[k]),
      .sat      (lane_sat_s[k])
    );
  end

  // Only lanes holding a real column may raise the saturation flag
  always_comb begin
    any_sat_s = 1'b0;
    for (int k = 32'sd0; k < LANES; k++) begin
      if (k < active_lanes_s && lane_sat_s[k]) begin
        any_sat_s = 1'b1;
      end else begin
        any_sat_s = any_sat_s;
      end
    end
  end

  // Result write-back one cycle after each row read, plus the sticky saturation flag
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 32'sd0; r < FEATURE_ROWS; r++) begin
        for (int c = 32'sd0; c < WEIGHT_COLS; c++) begin
          result_r[r][c] <= '0;
        end
      end
      sat_flag_r <= 1'b0;
    end else begin
      if (state_r == ST_IDLE && start) begin
        sat_flag_r <= 1'b0;
      end else if (wr_valid_r && any_sat_s) begin
        sat_flag_r <= 1'b1;
      end
      for (int r = 32'sd0; r < FEATURE_ROWS; r++) begin
        for (int c = 32'sd0; c < WEIGHT_COLS; c++) begin
          for (int k = 32'sd0; k < LANES; k++) begin
            if (wr_valid_r && int'(wr_row_r) == r && k < active_lanes_s
                && c == int'(group_r) * LANES + k) begin
              result_r[r][c] <= lane_result_s[k];
            end
          end
        end
      end
    end
  end

  // Row readout for the aggregation stage; out-of-range rows read as zero
  always_comb begin
    fm_wm_row_out = '0;
    for (int c = 32'sd0; c < WEIGHT_COLS; c++) begin
      if (int'(read_row) < FEATURE_ROWS) begin
        fm_wm_row_out[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH] = result_r[read_row][c];
      end else begin
        fm_wm_row_out[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH] = '0;
      end
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign enable_read  = enable_read_r;
  assign read_address = read_address_r;
  assign sat_flag     = sat_flag_r;

endmodule

// File: tb/tb_transformation_engine.sv
// Self-checking bench: three engines (defaults, 12-bit results, three lanes) share one
// memory image; results, timing and read traces are checked against a matrix model.
module tb_transformation_engine;

  localparam int FR = 6;
  localparam int FC = 96;
  localparam int WC = 3;
  localparam int DW = 5;
  localparam int AW = 13;

  logic clk = 1'b0;
  logic reset, start;
  logic [2:0] read_row;
  logic [FC*DW-1:0] data_a = '0, data_b = '0, data_c = '0;
  logic en_a, en_b, en_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic sat_a, sat_b, sat_c;
  logic [AW-1:0] addr_a, addr_b, addr_c;
  logic [WC*16-1:0] row_a, row_c;
  logic [WC*12-1:0] row_b;

  int feat_mem [FR][FC];
  int wt_mem [WC][FC];
  int exp_sum [FR][WC];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  transformation_engine u_a (
    .clk(clk), .reset(reset), .start(start), .data_in(data_a), .read_row(read_row),
    .enable_read(en_a), .read_address(addr_a), .busy(busy_a), .done(done_a),
    .sat_flag(sat_a), .fm_wm_row_out(row_a));

  transformation_engine #(.DOT_PROD_WIDTH(12)) u_b (
    .clk(clk), .reset(reset), .start(start), .data_in(data_b), .read_row(read_row),
    .enable_read(en_b), .read_address(addr_b), .busy(busy_b), .done(done_b),
    .sat_flag(sat_b), .fm_wm_row_out(row_b));

  transformation_engine #(.LANES(3)) u_c (
    .clk(clk), .reset(reset), .start(start), .data_in(data_c), .read_row(read_row),
    .enable_read(en_c), .read_address(addr_c), .busy(busy_c), .done(done_c),
    .sat_flag(sat_c), .fm_wm_row_out(row_c));

  function automatic logic [FC*DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [FC*DW-1:0] w;
    int ai;
    w = '0;
    ai = int'(a);
    for (int i = 0; i < FC; i++) begin
      if (ai >= 512 && ai < 512 + FR) w[i*DW +: DW] = DW'(feat_mem[ai-512][i]);
      else if (ai < WC) w[i*DW +: DW] = DW'(wt_mem[ai][i]);
    end
    return w;
  endfunction

  // One-cycle read latency memory, one port per engine
  always @(posedge clk) begin
    if (en_a) data_a <= mem_word(addr_a);
    if (en_b) data_b <= mem_word(addr_b);
    if (en_c) data_c <= mem_word(addr_c);
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int clampv(input int v, input int bits);
    int mx;
    mx = (1 << bits) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic int done_cycle(input int lanes);
    int g;
    g = (WC + lanes - 1) / lanes;
    return WC + g * (FR + 1) + 1;
  endfunction

  // j-th address of the expected read sequence: weight columns of a group, then all rows
  function automatic int addr_at(input int lanes, input int j);
    int idx, res;
    idx = 0;
    res = -1;
    for (int g = 0; g * lanes < WC; g++) begin
      for (int k = 0; k < lanes && g * lanes + k < WC; k++) begin
        if (idx == j) res = g * lanes + k;
        idx++;
      end
      for (int r = 0; r < FR; r++) begin
        if (idx == j) res = 512 + r;
        idx++;
      end
    end
    return res;
  endfunction

  task automatic fill(input int mode);
    for (int r = 0; r < FR; r++)
      for (int i = 0; i < FC; i++)
        case (mode)
          1: feat_mem[r][i] = 1;
          2: feat_mem[r][i] = r + 1;
          3: feat_mem[r][i] = 7;
          4: feat_mem[r][i] = int'($urandom_range(7));
          default: feat_mem[r][i] = 0;
        endcase
    for (int c = 0; c < WC; c++)
      for (int i = 0; i < FC; i++)
        case (mode)
          1: wt_mem[c][i] = 1;
          2: wt_mem[c][i] = c + 1;
          3: wt_mem[c][i] = 31;
          4: wt_mem[c][i] = int'($urandom_range(31));
          default: wt_mem[c][i] = 0;
        endcase
    for (int r = 0; r < FR; r++)
      for (int c = 0; c < WC; c++) begin
        exp_sum[r][c] = 0;
        for (int i = 0; i < FC; i++) exp_sum[r][c] += feat_mem[r][i] * wt_mem[c][i];
      end
  endtask

  task automatic check_results();
    int any12, any16;
    any12 = 0;
    any16 = 0;
    for (int r = 0; r < FR; r++) begin
      read_row = 3'(r);
      #1;
      for (int c = 0; c < WC; c++) begin
        check($sformatf("res_a[%0d][%0d]", r, c), row_a[c*16 +: 16], clampv(exp_sum[r][c], 16));
        check($sformatf("res_b[%0d][%0d]", r, c), row_b[c*12 +: 12], clampv(exp_sum[r][c], 12));
        check($sformatf("res_c[%0d][%0d]", r, c), row_c[c*16 +: 16], clampv(exp_sum[r][c], 16));
        if (exp_sum[r][c] > 4095) any12 = 1;
        if (exp_sum[r][c] > 65535) any16 = 1;
      end
    end
    check("sat_a", sat_a, any16);
    check("sat_b", sat_b, any12);
    check("sat_c", sat_c, any16);
  endtask

  task automatic check_zero(input string tag);
    for (int r = 0; r < FR; r++) begin
      read_row = 3'(r);
      #1;
      check($sformatf("%s_row_a%0d", tag, r), row_a, 0);
      check($sformatf("%s_row_b%0d", tag, r), row_b, 0);
      check($sformatf("%s_row_c%0d", tag, r), row_c, 0);
    end
  endtask

  // One job on all engines; optionally pulse start again at cycle pulse_at while busy
  task automatic run_job(input int pulse_at);
    int da, db, dc, na, nb, nc, ba, bc;
    int ta[$];
    int tc[$];
    da = 0; db = 0; dc = 0; na = 0; nb = 0; nc = 0; ba = 0; bc = 0;
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (n == 1) check("sat_clear_on_start", sat_b, 0);
      start = (n == pulse_at);
      if (done_a) begin na++; if (da == 0) da = n; end
      if (done_b) begin nb++; if (db == 0) db = n; end
      if (done_c) begin nc++; if (dc == 0) dc = n; end
      if (busy_a) ba++;
      if (busy_c) bc++;
      if (en_a) ta.push_back(int'(addr_a));
      if (en_c) tc.push_back(int'(addr_c));
    end
    check("done_cycle_a", da, done_cycle(2));
    check("done_cycle_b", db, done_cycle(2));
    check("done_cycle_c", dc, done_cycle(3));
    check("done_pulses_a", na, 1);
    check("done_pulses_b", nb, 1);
    check("done_pulses_c", nc, 1);
    check("busy_cycles_a", ba, done_cycle(2));
    check("busy_cycles_c", bc, done_cycle(3));
    check("trace_len_a", ta.size(), WC + 2 * FR);
    check("trace_len_c", tc.size(), WC + FR);
    for (int j = 0; j < WC + 2 * FR; j++)
      check($sformatf("trace_a[%0d]", j), (j < ta.size()) ? ta[j] : -1, addr_at(2, j));
    for (int j = 0; j < WC + FR; j++)
      check($sformatf("trace_c[%0d]", j), (j < tc.size()) ? tc[j] : -1, addr_at(3, j));
    check("idle_addr_hold_a", addr_a, 512 + FR - 1);
    check("idle_enable_a", en_a, 0);
  endtask

  typedef struct {
    int mode;
    int pulse_at;
    int exp_a00;
    int exp_b00;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int dq_a[$];
    int dq_c[$];
    int nd;

    tbl[0] = '{1, 0, 96, 96};
    tbl[1] = '{2, 0, 96, 96};
    tbl[2] = '{3, 0, 20832, 4095};
    tbl[3] = '{0, 0, 0, 0};
    tbl[4] = '{2, 5, 96, 96};
    tbl[5] = '{1, 9, 96, 96};

    reset = 1'b1;
    start = 1'b0;
    read_row = 3'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_enable", en_a, 0);
    check("rst_addr", addr_a, 0);
    check("rst_sat", sat_b, 0);
    check_zero("rst");

    for (int t = 0; t < 6; t++) begin
      fill(tbl[t].mode);
      run_job(tbl[t].pulse_at);
      read_row = 3'd0;
      #1;
      check($sformatf("tbl%0d_a00", t), row_a[15:0], tbl[t].exp_a00);
      check($sformatf("tbl%0d_b00", t), row_b[11:0], tbl[t].exp_b00);
      check_results();
    end

    for (int t = 0; t < 4; t++) begin
      fill(4);
      run_job(0);
      check_results();
    end

    // start held high: next job accepted in the idle cycle right after done
    fill(2);
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (n == 20) start = 1'b0;
      if (done_a) dq_a.push_back(n);
      if (done_c) dq_c.push_back(n);
    end
    check("b2b_count_a", dq_a.size(), 2);
    check("b2b_count_c", dq_c.size(), 2);
    check("b2b_first_a", (dq_a.size() > 0) ? dq_a[0] : -1, done_cycle(2));
    check("b2b_second_a", (dq_a.size() > 1) ? dq_a[1] : -1, 2 * done_cycle(2) + 1);
    check("b2b_second_c", (dq_c.size() > 1) ? dq_c[1] : -1, 2 * done_cycle(3) + 1);
    check_results();

    // reset during COMPUTE of group 1 aborts everything
    fill(4);
    @(negedge clk);
    start = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_busy", busy_a, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_enable", en_a, 0);
    check("mid_rst_addr", addr_a, 0);
    check("mid_rst_done", done_a, 0);
    check("mid_rst_sat", sat_b, 0);
    check_zero("mid_rst");
    nd = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_a || done_b || done_c || busy_a) nd++;
    end
    check("no_done_after_rst", nd, 0);
    fill(4);
    run_job(0);
    check_results();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
